// File: rtl/cu_seq.sv
`default_nettype none
// ============================================================================
//  Module   : cu_seq
//  Purpose  : Hardwired multi-cycle fetch/decode/execute control sequencer
//             driving one control bit per datapath action on CS_bus.
//  Revision : 1.0  initial release
// ============================================================================
module cu_seq #(
  parameter int RW      = 2,
  parameter int OPW     = 4,
  parameter int TIMEOUT = 255,
  parameter int CSW     = 15 + 2 * (2 ** RW) + 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [OPW+2*RW-1:0]   ins,
  input  logic                  MFC,
  output logic [CSW-1:0]        CS_bus,
  output logic                  halted,
  output logic                  illegal,
  output logic                  bus_err
);

  localparam int NREG = 2 ** RW;
  localparam int IW   = OPW + 2 * RW;

  localparam int C_PC_OUT      = 6;
  localparam int C_INC         = 7;
  localparam int C_WMFC        = 8;
  localparam int C_RNW         = 9;
  localparam int C_MAR_IN      = 10;
  localparam int C_MBR_OUT     = 11;
  localparam int C_IR_IN       = 12;
  localparam int C_Y_IN        = 13;
  localparam int C_Z_OUT       = 14;
  localparam int C_REG_IN_LSB  = 15;
  localparam int C_REG_OUT_LSB = 15 + NREG;
  localparam int C_ENDD        = CSW - 1;

  localparam logic [3:0] S_IDLE = 4'd0;
  localparam logic [3:0] S_F0   = 4'd1;
  localparam logic [3:0] S_F1   = 4'd2;
  localparam logic [3:0] S_F2   = 4'd3;
  localparam logic [3:0] S_E0   = 4'd4;
  localparam logic [3:0] S_E1   = 4'd5;
  localparam logic [3:0] S_E2   = 4'd6;
  localparam logic [3:0] S_EW   = 4'd7;
  localparam logic [3:0] S_HALT = 4'd8;

  localparam logic [OPW-1:0] C_OP_CMP  = OPW'(1);
  localparam logic [OPW-1:0] C_OP_ALU  = OPW'(5);
  localparam logic [OPW-1:0] C_OP_MOV  = OPW'(6);
  localparam logic [OPW-1:0] C_OP_LD   = OPW'(7);
  localparam logic [OPW-1:0] C_OP_NOP  = OPW'(8);
  localparam logic [OPW-1:0] C_OP_HALT = {OPW{1'b1}};

  // Wide enough to hold TIMEOUT itself so the compare below never aliases.
  localparam int              CNTW = $clog2(TIMEOUT + 2);
  localparam logic [CNTW:0]   C_TO = (CNTW + 1)'(TIMEOUT);

  logic [3:0]      r_state;
  logic [3:0]      w_next;
  logic [CNTW-1:0] r_wcnt;
  logic            r_bus_err;

  logic [OPW-1:0]  w_op;
  logic [RW-1:0]   w_rd;
  logic [RW-1:0]   w_rs;
  logic [NREG-1:0] w_rd_oh;
  logic [NREG-1:0] w_rs_oh;
  logic [5:0]      w_alu_oh;
  logic            w_is_alu;
  logic            w_is_cmp;
  logic            w_is_mov;
  logic            w_is_ld;
  logic            w_is_nop;
  logic            w_is_halt;
  logic            w_is_illegal;
  logic            w_wait;
  logic [CNTW:0]   w_cnt_inc;
  logic            w_timeout;
  logic [CSW-1:0]  w_cs;

  assign w_op = ins[IW-1 -: OPW];
  assign w_rd = ins[2*RW-1 -: RW];
  assign w_rs = ins[RW-1:0];

  assign w_rd_oh  = {{(NREG-1){1'b0}}, 1'b1} << w_rd;
  assign w_rs_oh  = {{(NREG-1){1'b0}}, 1'b1} << w_rs;
  assign w_alu_oh = 6'b000001 << w_op[2:0];

  assign w_is_alu     = (w_op <= C_OP_ALU);
  assign w_is_cmp     = (w_op == C_OP_CMP);
  assign w_is_mov     = (w_op == C_OP_MOV);
  assign w_is_ld      = (w_op == C_OP_LD);
  assign w_is_nop     = (w_op == C_OP_NOP);
  assign w_is_halt    = (w_op == C_OP_HALT);
  assign w_is_illegal = !(w_is_alu || w_is_mov || w_is_ld || w_is_nop || w_is_halt);

  assign w_wait    = (r_state == S_F1) || (r_state == S_EW);
  assign w_cnt_inc = {1'b0, r_wcnt} + {{CNTW{1'b0}}, 1'b1};
  // A completing MFC on the timeout edge takes priority over the error.
  assign w_timeout = (TIMEOUT != 0) && w_wait && !MFC && (w_cnt_inc >= C_TO);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: w_next = S_F0;
      S_F0:   w_next = S_F1;
      S_F1: begin
        if (MFC)            w_next = S_F2;
        else if (w_timeout) w_next = S_HALT;
      end
      S_F2:   w_next = S_E0;
      S_E0: begin
        if (w_is_alu)       w_next = S_E1;
        else if (w_is_ld)   w_next = S_EW;
        else if (w_is_halt) w_next = S_HALT;
        else                w_next = S_F0;
      end
      S_EW: begin
        if (MFC)            w_next = S_E1;
        else if (w_timeout) w_next = S_HALT;
      end
      S_E1:   w_next = w_is_alu ? S_E2 : S_F0;
      S_E2:   w_next = S_F0;
      S_HALT: w_next = S_HALT;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= S_IDLE;
      r_wcnt    <= '0;
      r_bus_err <= 1'b0;
    end else begin
      r_state <= w_next;
      if (!w_wait)
        r_wcnt <= '0;
      else if (!(&r_wcnt))
        r_wcnt <= w_cnt_inc[CNTW-1:0];
      if (w_timeout)
        r_bus_err <= 1'b1;
    end
  end

  always_comb begin
    w_cs = '0;
    case (r_state)
      S_F0: begin
        w_cs[C_PC_OUT] = 1'b1;
        w_cs[C_MAR_IN] = 1'b1;
        w_cs[C_INC]    = 1'b1;
        w_cs[C_RNW]    = 1'b1;
      end
      S_F1, S_EW: begin
        w_cs[C_WMFC] = 1'b1;
        w_cs[C_RNW]  = 1'b1;
      end
      S_F2: begin
        w_cs[C_MBR_OUT] = 1'b1;
        w_cs[C_IR_IN]   = 1'b1;
      end
      S_E0: begin
        if (w_is_alu) begin
          w_cs[C_REG_OUT_LSB +: NREG] = w_rd_oh;
          w_cs[C_Y_IN]                = 1'b1;
        end else if (w_is_mov) begin
          w_cs[C_REG_OUT_LSB +: NREG] = w_rs_oh;
          w_cs[C_REG_IN_LSB +: NREG]  = w_rd_oh;
          w_cs[C_ENDD]                = 1'b1;
        end else if (w_is_ld) begin
          w_cs[C_REG_OUT_LSB +: NREG] = w_rs_oh;
          w_cs[C_MAR_IN]              = 1'b1;
          w_cs[C_RNW]                 = 1'b1;
        end else begin
          w_cs[C_ENDD] = 1'b1;
        end
      end
      S_E1: begin
        if (w_is_ld) begin
          w_cs[C_MBR_OUT]            = 1'b1;
          w_cs[C_REG_IN_LSB +: NREG] = w_rd_oh;
          w_cs[C_ENDD]               = 1'b1;
        end else if (w_is_alu) begin
          w_cs[C_REG_OUT_LSB +: NREG] = w_rs_oh;
          w_cs[5:0]                   = w_alu_oh;
        end
      end
      S_E2: begin
        if (w_is_cmp) begin
          w_cs[C_ENDD] = 1'b1;
        end else if (w_is_alu) begin
          w_cs[C_Z_OUT]              = 1'b1;
          w_cs[C_REG_IN_LSB +: NREG] = w_rd_oh;
          w_cs[C_ENDD]               = 1'b1;
        end
      end
      default: w_cs = '0;
    endcase
  end

  assign CS_bus  = w_cs;
  assign halted  = (r_state == S_HALT);
  assign illegal = (r_state == S_E0) && w_is_illegal;
  assign bus_err = r_bus_err;

endmodule
`default_nettype wire
